rv32i_fetch: RTL and testbench

Instruction fetch stage for the RV32I core; it drives the instruction memory and hands `pc`/`inst` pairs to the decode stage. It holds a single outstanding request, buffers one returned instruction when decode stalls (skid entry), and redirects on branch/jump/trap PC changes. Its outputs `o_pc`/`o_inst` connect directly to the decoder's `pc`/`inst` inputs.

---
 rtl/rv32i_fetch.sv | 137 +++++++++++++
 tb/tb_rv32i_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch.sv
// rv32i_fetch: instruction fetch stage for the RV32I core.
// Keeps one memory request in flight, hands pc/inst pairs to decode, holds one
// extra returned instruction in a skid entry while decode stalls, and
// restarts fetch at a new PC on branch/jump/trap redirects.
module rv32i_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] o_iaddr,
  output logic        o_stb_inst,
  input  logic        i_ack_inst,
  input  logic [31:0] i_inst,
  input  logic        i_stall,
  input  logic        i_change_pc,
  input  logic [31:0] i_new_pc,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_valid
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SKID = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        skid_vld_q, skid_vld_d;

  logic        ack_acc;
  logic        out_ready;

  // A request is outstanding only in RUN; BOOT and SKID keep the bus idle.
  assign o_stb_inst = (state_q == ST_RUN);
  // A response racing a redirect belongs to the flushed path and is dropped.
  assign ack_acc    = o_stb_inst && i_ack_inst && !i_change_pc;
  // The output register may take a new pair when it is empty or being consumed.
  assign out_ready  = !valid_q || !i_stall;

  assign o_iaddr = iaddr_q;
  assign o_pc    = pc_q;
  assign o_inst  = inst_q;
  assign o_valid = valid_q;

  // Next-state logic: FSM, output register, skid entry and fetch address.
  always_comb begin
    state_d     = state_q;
    iaddr_d     = iaddr_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    skid_vld_d  = skid_vld_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Decode took the current pair; it empties unless refilled below.
        if (valid_q && !i_stall) begin
          valid_d = 1'b0;
        end
        if (ack_acc) begin
          iaddr_d = iaddr_q + 32'd4;
          if (out_ready && !skid_vld_q) begin
            pc_d    = iaddr_q;
            inst_d  = i_inst;
            valid_d = 1'b1;
          end else begin
            // Output is held by a stall: park the word and stop requesting
            // so no more than one instruction piles up behind the output.
            skid_pc_d   = iaddr_q;
            skid_inst_d = i_inst;
            skid_vld_d  = 1'b1;
            state_d     = ST_SKID;
          end
        end
      end
      ST_SKID: begin
        // Drain cycle: the skid replaces the consumed output pair. The next
        // request only goes out once back in RUN.
        if (!i_stall) begin
          pc_d       = skid_pc_q;
          inst_d     = skid_inst_q;
          valid_d    = 1'b1;
          skid_vld_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Redirect wins over stall, ack and drain: everything fetched is stale.
    // The target is taken as-is; misalignment is decode's concern.
    if (i_change_pc) begin
      iaddr_d    = i_new_pc;
      valid_d    = 1'b0;
      skid_vld_d = 1'b0;
      state_d    = ST_RUN;
    end
  end

  // Control state and output pair, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      iaddr_q    <= PC_RESET;
      pc_q       <= 32'd0;
      inst_q     <= 32'd0;
      valid_q    <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      iaddr_q    <= iaddr_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Skid payload; only meaningful while skid_vld_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_pc_q   <= skid_pc_d;
    skid_inst_q <= skid_inst_d;
  end

endmodule

// File: tb/tb_rv32i_fetch.sv
// Bench for rv32i_fetch: directed stimulus with a scoreboard of expected
// consumed PCs, a behavioral instruction memory with programmable wait states,
// and a monitor that checks every pair decode takes.
module tb_rv32i_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] o_iaddr;
  logic        o_stb_inst;
  logic        i_ack_inst;
  logic [31:0] i_inst;
  logic        i_stall;
  logic        i_change_pc;
  logic [31:0] i_new_pc;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        o_valid;

  int          n_vec = 0;
  int          n_err = 0;
  int          wait_n = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rv32i_fetch #(.PC_RESET(32'h0000_0100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .o_iaddr     (o_iaddr),
    .o_stb_inst  (o_stb_inst),
    .i_ack_inst  (i_ack_inst),
    .i_inst      (i_inst),
    .i_stall     (i_stall),
    .i_change_pc (i_change_pc),
    .i_new_pc    (i_new_pc),
    .o_pc        (o_pc),
    .o_inst      (o_inst),
    .o_valid     (o_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: acks after wait_n idle cycles of a stable request.
  initial begin : mem
    int          wcnt;
    logic [31:0] prev_addr;
    logic        prev_stb;
    wcnt       = 0;
    prev_addr  = 32'd0;
    prev_stb   = 1'b0;
    i_ack_inst = 1'b0;
    i_inst     = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (!o_stb_inst || !prev_stb || o_iaddr != prev_addr) wcnt = 0;
      else wcnt++;
      prev_stb   = o_stb_inst;
      prev_addr  = o_iaddr;
      i_ack_inst = o_stb_inst && (wcnt >= wait_n);
      i_inst     = i_ack_inst ? mem_word(o_iaddr) : 32'd0;
    end
  end

  // Monitor: every pair decode consumes must be the next expected one.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (rst_n && o_valid && !i_stall) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL consume_extra: got pc %h, expected no delivery", o_pc);
      end else begin
        e = exp_q.pop_front();
        chk("consume_pc", o_pc, e);
        chk("consume_inst", o_inst, mem_word(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    i_stall     = 1'b0;
    i_change_pc = 1'b0;
    i_new_pc    = 32'd0;
    repeat (3) tick();
    chk("rst_iaddr", o_iaddr, 32'h100);
    chk("rst_stb",   {31'd0, o_stb_inst}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_pc",    o_pc, 32'd0);
    chk("rst_inst",  o_inst, 32'd0);

    // Boot and zero-wait streaming, then a 4-cycle stall with o_pc=0x104.
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    exp_q.push_back(32'h10C);
    exp_q.push_back(32'h110);
    rst_n = 1'b1;
    chk("boot_stb_low", {31'd0, o_stb_inst}, 32'd0);
    tick();
    chk("boot_stb_high", {31'd0, o_stb_inst}, 32'd1);
    chk("boot_iaddr", o_iaddr, 32'h100);
    tick();
    chk("first_valid", {31'd0, o_valid}, 32'd1);
    chk("first_pc", o_pc, 32'h100);
    tick();
    chk("second_pc", o_pc, 32'h104);
    i_stall = 1'b1;
    tick();
    chk("skid_stb_low", {31'd0, o_stb_inst}, 32'd0);
    chk("skid_hold_pc", o_pc, 32'h104);
    chk("skid_iaddr", o_iaddr, 32'h10C);
    repeat (3) tick();
    chk("stall_hold_pc", o_pc, 32'h104);
    i_stall = 1'b0;
    tick();
    chk("drain_pc", o_pc, 32'h108);
    chk("drain_valid", {31'd0, o_valid}, 32'd1);
    chk("drain_stb", {31'd0, o_stb_inst}, 32'd1);
    tick();
    chk("after_drain_pc", o_pc, 32'h10C);

    // Three wait states per request.
    wait_n = 3;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("wait_iaddr_stable", o_iaddr, 32'h110 + 32'(4 * r));
        chk("wait_valid_low", {31'd0, o_valid}, 32'd0);
      end
      tick();
      chk("wait_valid_pulse", {31'd0, o_valid}, 32'd1);
      chk("wait_pc", o_pc, 32'h110 + 32'(4 * r));
    end

    // Redirect with stall and ack in the same cycle; held 0x114 is flushed.
    wait_n      = 0;
    i_stall     = 1'b1;
    i_change_pc = 1'b1;
    i_new_pc    = 32'h200;
    exp_q.push_back(32'h200);
    tick();
    chk("redir_valid_low", {31'd0, o_valid}, 32'd0);
    chk("redir_iaddr", o_iaddr, 32'h200);
    chk("redir_stb", {31'd0, o_stb_inst}, 32'd1);
    i_change_pc = 1'b0;
    i_stall     = 1'b0;
    tick();
    chk("redir_first_pc", o_pc, 32'h200);
    chk("redir_first_valid", {31'd0, o_valid}, 32'd1);
    tick();
    chk("redir_second_pc", o_pc, 32'h204);
    i_stall = 1'b1;
    tick();
    chk("skid2_stb_low", {31'd0, o_stb_inst}, 32'd0);

    // Redirect out of SKID to the top word: skid cleared, address wraps.
    i_change_pc = 1'b1;
    i_new_pc    = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC);
    tick();
    chk("wrap_valid_low", {31'd0, o_valid}, 32'd0);
    chk("wrap_iaddr", o_iaddr, 32'hFFFF_FFFC);
    i_change_pc = 1'b0;
    i_stall     = 1'b0;
    tick();
    chk("wrap_next_iaddr", o_iaddr, 32'h0);
    chk("wrap_pc", o_pc, 32'hFFFF_FFFC);

    // Misaligned redirect target is forwarded unchanged.
    i_change_pc = 1'b1;
    i_new_pc    = 32'h102;
    exp_q.push_back(32'h102);
    exp_q.push_back(32'h106);
    tick();
    chk("mis_iaddr", o_iaddr, 32'h102);
    chk("mis_valid_low", {31'd0, o_valid}, 32'd0);
    i_change_pc = 1'b0;
    tick();
    chk("mis_pc0", o_pc, 32'h102);
    tick();
    chk("mis_pc1", o_pc, 32'h106);
    tick();
    chk("mis_pc2", o_pc, 32'h10A);
    i_stall = 1'b1;
    tick();
    chk("skid3_stb_low", {31'd0, o_stb_inst}, 32'd0);

    // Reset while stalled with the skid full.
    rst_n = 1'b0;
    tick();
    chk("mid_rst_iaddr", o_iaddr, 32'h100);
    chk("mid_rst_stb",   {31'd0, o_stb_inst}, 32'd0);
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_pc",    o_pc, 32'd0);
    chk("mid_rst_inst",  o_inst, 32'd0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    rst_n   = 1'b1;
    i_stall = 1'b0;
    chk("reboot_stb_low", {31'd0, o_stb_inst}, 32'd0);
    tick();
    chk("reboot_stb_high", {31'd0, o_stb_inst}, 32'd1);
    chk("reboot_iaddr", o_iaddr, 32'h100);
    tick();
    chk("reboot_pc0", o_pc, 32'h100);
    tick();
    chk("reboot_pc1", o_pc, 32'h104);
    tick();
    chk("reboot_pc2", o_pc, 32'h108);
    chk("reboot_valid", {31'd0, o_valid}, 32'd1);
    i_stall = 1'b1;
    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
